mem_wb_elastic: RTL and testbench
=================================

Name: mem_wb_elastic

Overview:
- Parametrised successor to the fixed 16-bit MEM/WB stage register.
- Adds a valid/ready elastic handshake with a 2-entry skid buffer.
- Adds a synchronous flush, a destination-register field and the write-back data mux.
- Sits between the memory stage and register-file write port; decouples memory-stage back-pressure from write-back.

Parameters:
- DATA_W, 16, width of ALU result, memory data and write-back data.
- REG_ADDR_W, 4, width of destination register index.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; drops all held and incoming entries.
- in_valid  in  1  memory stage presents an entry.
- in_ready  out  1  stage can accept; registered.
- in_write_reg  in  1  entry writes the register file.
- in_dst_reg  in  REG_ADDR_W  destination register index.
- in_mem_to_reg  in  1  1 selects memory data, 0 selects ALU result.
- in_alu_res  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  data-memory read data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back consumes the head.
- out_write_reg  out  1  head write enable, gated by out_valid.
- out_dst_reg  out  REG_ADDR_W  head destination index.
- out_alu_res  out  DATA_W  head ALU result.
- out_mem_data  out  DATA_W  head memory data.
- out_wb_data  out  DATA_W  out_mem_to_reg ? out_mem_data : out_alu_res (combinational from the head).

Behaviour:
- Storage: main slot (drives outputs) plus one skid slot. Each slot holds write_reg, dst_reg, mem_to_reg, alu_res, mem_data and a valid bit.
- Handshake events: acc = in_valid & in_ready; iss = out_valid & out_ready.
- State from valid bits: EMPTY (none), ONE (main only), FULL (main+skid). Skid valid with main invalid is illegal.
- EMPTY: acc → load main → ONE.
- ONE:
  - acc & iss → main reloaded from input, stays ONE.
  - acc & !iss → input goes to skid → FULL.
  - !acc & iss → EMPTY.
- FULL: in_ready=0, so no acc. iss → skid moves to main, skid cleared → ONE.
- in_ready next = !(next state == FULL). Registered; never combinationally depends on out_ready.
- Latency: an entry accepted in cycle N is at the outputs in N+1 when the stage was EMPTY, or when it was in ONE and iss occurred.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or rst.
- Payload is held stable while out_valid=1 and out_ready=0.
- out_valid=0 → out_write_reg=0, regardless of stored payload. A bubble never writes the register file.
- flush=1 at a clock edge: both valid bits clear, state → EMPTY, in_ready=1 next cycle.
  - A simultaneous acc is discarded.
  - A simultaneous iss still counts as consumed by the downstream.
  - Payload registers may retain stale values.
- flush takes priority over all transitions.
- rst (async, any time, including mid-transfer):
  - valid bits 0, all payload registers 0.
  - in_ready=1, out_valid=0, out_write_reg=0, out_dst_reg=0, out_alu_res=0, out_mem_data=0, out_wb_data=0.
  - Stall counter 0.
- Widths: all data paths are DATA_W with no extension or truncation. out_wb_data is a pure mux.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [STALL_CNT_W-1:0].
  - Increments each cycle out_valid & !out_ready.
  - Saturates at all-ones; cleared by rst only, not by flush.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Decomposition:
- Package mem_wb_pkg:
  - constants DEF_DATA_W=16, DEF_REG_ADDR_W=4.
  - typedef wb_entry_t struct: write_reg, dst_reg, mem_to_reg, alu_res, mem_data.
  - typedef enum slot_state_e: EMPTY, ONE, FULL.
- Sub-module pipe_slot: one wb_entry_t register plus valid bit, with load, clear and async reset. Instantiated twice (main, skid).

Test Plan:
- Reset mid-stream: FULL state, assert rst for half a cycle → outputs immediately 0, in_valid/out_valid 0/0, in_ready=1 after the next edge.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with alu_res 0x0001..0x0004, mem_to_reg=0 → out_wb_data 0x0001..0x0004 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure: out_ready=0, push A(0x1111), B(0x2222) → in_ready=0 after B, outputs hold A. Release out_ready → A then B, in_ready=1 the cycle after A issues.
- Mux and gating:
  - entry mem_to_reg=1, mem_data=0xBEEF, alu_res=0x1234 → out_wb_data=0xBEEF.
  - dst_reg=4'hA, write_reg=1 → out_write_reg=1 only while out_valid=1.
- Flush: FULL state plus in_valid=1 with flush=1 → next cycle out_valid=0, in_ready=1, out_write_reg=0. The incoming entry never appears.
- With MEM_WB_STALL_CNT_EN, STALL_CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cycles=4'hF (saturated).

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB elastic stage: default widths, the write-back entry
// record and the occupancy states of the two-slot skid buffer.
package mem_wb_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 4;

    typedef struct packed {
        logic                      write_reg;
        logic [DEF_REG_ADDR_W-1:0] dst_reg;
        logic                      mem_to_reg;
        logic [DEF_DATA_W-1:0]     alu_res;
        logic [DEF_DATA_W-1:0]     mem_data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

    // A valid skid slot behind an empty main slot cannot occur; it is folded into FULL.
    function automatic slot_state_e decode_state(input logic main_valid, input logic skid_valid);
        if (skid_valid)      return FULL;
        else if (main_valid) return ONE;
        else                 return EMPTY;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffered write-back entry with its valid bit; clear wins over load and
// leaves the payload untouched, reset zeroes everything.
module pipe_slot #(
    parameter type entry_t = mem_wb_pkg::wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_clear,
    input  entry_t i_data,
    output logic   o_valid,
    output entry_t o_data
);

    logic   r_valid;
    entry_t r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM/WB stage register with a valid/ready handshake and a two-entry skid buffer.
// Optional stall-cycle counter is enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_elastic
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef MEM_WB_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_write_reg,
    input  logic [REG_ADDR_W-1:0] in_dst_reg,
    input  logic                  in_mem_to_reg,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [DATA_W-1:0]     in_mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_write_reg,
    output logic [REG_ADDR_W-1:0] out_dst_reg,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [DATA_W-1:0]     out_wb_data
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    typedef struct packed {
        logic                  write_reg;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic                  mem_to_reg;
        logic [DATA_W-1:0]     alu_res;
        logic [DATA_W-1:0]     mem_data;
    } entry_t;

    logic        r_inReady;
    logic        w_acc;
    logic        w_iss;
    logic        w_mainValid;
    logic        w_skidValid;
    logic        w_mainLoad;
    logic        w_mainClear;
    logic        w_mainFromSkid;
    logic        w_skidLoad;
    logic        w_skidClear;
    entry_t      w_inEntry;
    entry_t      w_mainIn;
    entry_t      w_mainData;
    entry_t      w_skidData;
    slot_state_e w_state;
    slot_state_e w_nextState;

    assign w_inEntry = '{write_reg:  in_write_reg,
                         dst_reg:    in_dst_reg,
                         mem_to_reg: in_mem_to_reg,
                         alu_res:    in_alu_res,
                         mem_data:   in_mem_data};

    assign w_acc    = in_valid & r_inReady;
    assign w_iss    = w_mainValid & out_ready;
    assign w_state  = decode_state(w_mainValid, w_skidValid);
    assign w_mainIn = w_mainFromSkid ? w_skidData : w_inEntry;

    // The slot valid bits hold the state; this only registers the accept flag,
    // so in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inReady <= 1'b1;
        end else begin
            r_inReady <= (w_nextState != FULL);
        end
    end

    always_comb begin
        w_mainLoad     = 1'b0;
        w_mainClear    = 1'b0;
        w_mainFromSkid = 1'b0;
        w_skidLoad     = 1'b0;
        w_skidClear    = 1'b0;
        w_nextState    = w_state;
        if (flush) begin
            w_mainClear = 1'b1;
            w_skidClear = 1'b1;
            w_nextState = EMPTY;
        end else begin
            case (w_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_mainLoad  = 1'b1;
                        w_nextState = ONE;
                    end
                end
                ONE: begin
                    if (w_acc && w_iss) begin
                        w_mainLoad = 1'b1;
                    end else if (w_acc) begin
                        w_skidLoad  = 1'b1;
                        w_nextState = FULL;
                    end else if (w_iss) begin
                        w_mainClear = 1'b1;
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_iss) begin
                        w_mainLoad     = 1'b1;
                        w_mainFromSkid = 1'b1;
                        w_skidClear    = 1'b1;
                        w_nextState    = ONE;
                    end
                end
                default: w_nextState = EMPTY;
            endcase
        end
    end

    pipe_slot #(.entry_t(entry_t)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_mainLoad),
        .i_clear (w_mainClear),
        .i_data  (w_mainIn),
        .o_valid (w_mainValid),
        .o_data  (w_mainData)
    );

    pipe_slot #(.entry_t(entry_t)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_data  (w_inEntry),
        .o_valid (w_skidValid),
        .o_data  (w_skidData)
    );

    assign in_ready      = r_inReady;
    assign out_valid     = w_mainValid;
    assign out_write_reg = w_mainValid & w_mainData.write_reg;
    assign out_dst_reg   = w_mainData.dst_reg;
    assign out_alu_res   = w_mainData.alu_res;
    assign out_mem_data  = w_mainData.mem_data;
    assign out_wb_data   = w_mainData.mem_to_reg ? w_mainData.mem_data : w_mainData.alu_res;

`ifdef MEM_WB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stallCnt;

    // Saturating count of cycles the head waits on write-back; flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_mainValid && !out_ready && (r_stallCnt != {STALL_CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign stall_cycles = r_stallCnt;
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Bench for mem_wb_elastic: directed scenarios plus random traffic against a
// two-deep FIFO reference model. Define MEM_WB_STALL_CNT_EN to cover the stall counter.
module tb_mem_wb_elastic;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_write_reg;
    logic [3:0]  in_dst_reg;
    logic        in_mem_to_reg;
    logic [15:0] in_alu_res;
    logic [15:0] in_mem_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_write_reg;
    logic [3:0]  out_dst_reg;
    logic [15:0] out_alu_res;
    logic [15:0] out_mem_data;
    logic [15:0] out_wb_data;
`ifdef MEM_WB_STALL_CNT_EN
    logic [3:0]  stall_cycles;
`endif

    typedef struct {
        logic        wr;
        logic [3:0]  dst;
        logic        m2r;
        logic [15:0] alu;
        logic [15:0] mem;
    } ent_t;

    ent_t q[$];
    int   stallModel = 0;
    int   vectors    = 0;
    int   fails      = 0;

    mem_wb_elastic #(
        .DATA_W     (16),
        .REG_ADDR_W (4)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .STALL_CNT_W (4)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_write_reg  (in_write_reg),
        .in_dst_reg    (in_dst_reg),
        .in_mem_to_reg (in_mem_to_reg),
        .in_alu_res    (in_alu_res),
        .in_mem_data   (in_mem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_write_reg (out_write_reg),
        .out_dst_reg   (out_dst_reg),
        .out_alu_res   (out_alu_res),
        .out_mem_data  (out_mem_data),
        .out_wb_data   (out_wb_data)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic [3:0] dst,
                                 input logic m2r, input logic [15:0] alu, input logic [15:0] mem,
                                 input logic ordy, input logic fl);
        in_valid      = v;
        in_write_reg  = wr;
        in_dst_reg    = dst;
        in_mem_to_reg = m2r;
        in_alu_res    = alu;
        in_mem_data   = mem;
        out_ready     = ordy;
        flush         = fl;
    endtask

    // Reference model: a FIFO of capacity two; ready means room for one more entry.
    task automatic stepCycle();
        @(posedge clk);
        if (!rst) begin
            bit   canAccept;
            bit   haveHead;
            ent_t e;
            canAccept = (q.size() < 2);
            haveHead  = (q.size() > 0);
            e = '{wr: in_write_reg, dst: in_dst_reg, m2r: in_mem_to_reg,
                  alu: in_alu_res, mem: in_mem_data};
            if (haveHead && !out_ready) stallModel++;
            if (flush) begin
                q.delete();
            end else begin
                if (haveHead && out_ready) void'(q.pop_front());
                if (in_valid && canAccept) q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        bit   haveHead;
        ent_t h;
        haveHead = (q.size() > 0);
        cmp({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        cmp({tag, ".out_valid"}, 32'(out_valid), 32'(haveHead));
        if (haveHead) begin
            h = q[0];
            cmp({tag, ".write_reg"}, 32'(out_write_reg), 32'(h.wr));
            cmp({tag, ".dst_reg"}, 32'(out_dst_reg), 32'(h.dst));
            cmp({tag, ".alu_res"}, 32'(out_alu_res), 32'(h.alu));
            cmp({tag, ".mem_data"}, 32'(out_mem_data), 32'(h.mem));
            cmp({tag, ".wb_data"}, 32'(out_wb_data), 32'(h.m2r ? h.mem : h.alu));
        end else begin
            cmp({tag, ".write_reg_bubble"}, 32'(out_write_reg), 32'd0);
        end
`ifdef MEM_WB_STALL_CNT_EN
        cmp({tag, ".stall_cycles"}, 32'(stall_cycles), 32'((stallModel > 15) ? 15 : stallModel));
`endif
    endtask

    task automatic resetCheck(input string tag);
        cmp({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        cmp({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        cmp({tag, ".write_reg"}, 32'(out_write_reg), 32'd0);
        cmp({tag, ".dst_reg"}, 32'(out_dst_reg), 32'd0);
        cmp({tag, ".alu_res"}, 32'(out_alu_res), 32'd0);
        cmp({tag, ".mem_data"}, 32'(out_mem_data), 32'd0);
        cmp({tag, ".wb_data"}, 32'(out_wb_data), 32'd0);
`ifdef MEM_WB_STALL_CNT_EN
        cmp({tag, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        resetCheck("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stepCycle();
        checkOutput("idle");

        // Streaming: one entry per cycle, one-cycle latency.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b1, 4'(k), 1'b0, 16'(k), 16'hF000 + 16'(k), 1'b1, 1'b0);
            stepCycle();
            checkOutput("stream");
            cmp("stream.wb_explicit", 32'(out_wb_data), 32'(k));
            cmp("stream.ready_explicit", 32'(in_ready), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("drain");

        // Back-pressure: A and B fill the buffer, then drain in order.
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, 16'h1111, 16'h0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("bp.A");
        applyStimulus(1'b1, 1'b1, 4'h2, 1'b0, 16'h2222, 16'h0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("bp.B");
        cmp("bp.full_ready", 32'(in_ready), 32'd0);
        cmp("bp.hold_A", 32'(out_wb_data), 32'h1111);
        applyStimulus(1'b1, 1'b1, 4'h3, 1'b0, 16'h3333, 16'h0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("bp.hold");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("bp.issueA");
        cmp("bp.head_B", 32'(out_wb_data), 32'h2222);
        cmp("bp.ready_back", 32'(in_ready), 32'd1);
        stepCycle();
        checkOutput("bp.issueB");

        // Write-back mux and write-enable gating.
        applyStimulus(1'b1, 1'b1, 4'hA, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
        stepCycle();
        checkOutput("mux");
        cmp("mux.wb_mem", 32'(out_wb_data), 32'hBEEF);
        cmp("mux.wr_valid", 32'(out_write_reg), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("mux.bubble");
        cmp("mux.wr_gated", 32'(out_write_reg), 32'd0);

        // Flush while full with an incoming entry.
        applyStimulus(1'b1, 1'b1, 4'h5, 1'b0, 16'h5555, 16'h0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 4'h6, 1'b0, 16'h6666, 16'h0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("flush.full");
        applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, 16'h7777, 16'h0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("flush");
        cmp("flush.valid", 32'(out_valid), 32'd0);
        cmp("flush.ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("flush.after");

        // Asynchronous reset while full.
        applyStimulus(1'b1, 1'b1, 4'h8, 1'b1, 16'h8888, 16'h9999, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rstmid.full");
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        q.delete();
        stallModel = 0;
        resetCheck("rstmid");
        #2;
        rst = 1'b0;
        stepCycle();
        checkOutput("rstmid.after");

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                          1'($urandom), 16'($urandom), 16'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            stepCycle();
            checkOutput("rand");
        end

`ifdef MEM_WB_STALL_CNT_EN
        // Stall counter saturation with the head held for 20 cycles.
        applyStimulus(1'b1, 1'b1, 4'h3, 1'b0, 16'h0C0C, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("stall");
        end
        cmp("stall.saturated", 32'(stall_cycles), 32'hF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
